mem_access: RTL and testbench

Pipeline MEM stage, directly downstream of the EX stage. It registers the EX results and forwards branch resolution to fetch. For loads and stores it runs a req/ack transaction on the data-memory port, holding the pipeline with a stall while the transaction is outstanding. It delivers write-back data and control to the WB stage.

---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 188 ++++++++++++++++++
 tb/tb_mem_access.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory req/ack port bundle for the MEM stage
interface mem_access_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req_87;
  logic                  dmem_we_87;
  logic [ADDR_WIDTH-1:0] dmem_addr_87;
  logic [DATA_WIDTH-1:0] dmem_wdata_87;
  logic [DATA_WIDTH-1:0] dmem_rdata_87;
  logic                  dmem_ack_87;

  modport master (
    output dmem_req_87, dmem_we_87, dmem_addr_87, dmem_wdata_87,
    input  dmem_rdata_87, dmem_ack_87
  );

  modport slave (
    input  dmem_req_87, dmem_we_87, dmem_addr_87, dmem_wdata_87,
    output dmem_rdata_87, dmem_ack_87
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline MEM stage with req/ack data-memory port, stall and timeout
module mem_access #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk_87,
  input  logic                   rst_n_87,
  input  logic                   zero_in_87,
  input  logic [ADDR_WIDTH-1:0]  br_addr_in_87,
  input  logic [DATA_WIDTH-1:0]  alu_in_87,
  input  logic [DATA_WIDTH-1:0]  st_data_in_87,
  input  logic [RADDR_WIDTH-1:0] wb_radr_in_87,
  input  logic                   branch_in_87,
  input  logic                   mem_read_in_87,
  input  logic                   mem_write_in_87,
  input  logic                   reg_write_in_87,
  input  logic                   mem_2_reg_in_87,
  output logic                   stall_87,
  output logic                   pc_src_87,
  output logic [ADDR_WIDTH-1:0]  br_addr_out_87,
  mem_access_if.master           dmem,
  output logic [DATA_WIDTH-1:0]  rd_data_out_87,
  output logic [DATA_WIDTH-1:0]  alu_out_87,
  output logic [RADDR_WIDTH-1:0] wb_radr_out_87,
  output logic                   reg_write_out_87,
  output logic                   mem_2_reg_out_87,
  output logic                   err_87
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pc_src_q, pc_src_d;
  logic [ADDR_WIDTH-1:0]  br_addr_q, br_addr_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]  alu_q, alu_d;
  logic [RADDR_WIDTH-1:0] wb_radr_q, wb_radr_d;
  logic                   reg_write_q, reg_write_d;
  logic                   mem_2_reg_q, mem_2_reg_d;
  logic                   err_q, err_d;
  // reg_write of the instruction in flight, held back until it completes
  logic                   pend_rw_q, pend_rw_d;
  logic                   is_load_q, is_load_d;

  logic mem_op;
  logic aligned;

  assign mem_op  = mem_read_in_87 | mem_write_in_87;
  assign aligned = (alu_in_87[1:0] == 2'b00);

  // Next-state, output-register and stall computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_src_d    = pc_src_q;
    br_addr_d   = br_addr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    alu_d       = alu_q;
    wb_radr_d   = wb_radr_q;
    reg_write_d = reg_write_q;
    mem_2_reg_d = mem_2_reg_q;
    err_d       = err_q;
    pend_rw_d   = pend_rw_q;
    is_load_d   = is_load_q;
    stall_87    = 1'b0;

    case (state_q)
      IDLE: begin
        alu_d       = alu_in_87;
        wb_radr_d   = wb_radr_in_87;
        mem_2_reg_d = mem_2_reg_in_87;
        br_addr_d   = br_addr_in_87;
        if (!mem_op) begin
          pc_src_d    = branch_in_87 & zero_in_87;
          reg_write_d = reg_write_in_87;
        end else if (!aligned) begin
          // misaligned access: flag it and retire the instruction as a bubble
          err_d       = 1'b1;
          pc_src_d    = 1'b0;
          reg_write_d = 1'b0;
        end else begin
          stall_87    = 1'b1;
          state_d     = BUSY;
          cnt_d       = '0;
          req_d       = 1'b1;
          addr_d      = ADDR_WIDTH'(alu_in_87);
          we_d        = mem_write_in_87 & ~mem_read_in_87;
          wdata_d     = st_data_in_87;
          pend_rw_d   = reg_write_in_87;
          is_load_d   = mem_read_in_87;
          pc_src_d    = 1'b0;
          reg_write_d = 1'b0;
        end
      end

      BUSY: begin
        stall_87 = ~dmem.dmem_ack_87;
        cnt_d    = cnt_q + CW'(1);
        if (dmem.dmem_ack_87) begin
          // ack wins even in the cycle the timeout would fire
          state_d     = IDLE;
          req_d       = 1'b0;
          reg_write_d = pend_rw_q;
          if (is_load_q) begin
            rd_data_d = dmem.dmem_rdata_87;
          end
        end else if (cnt_d == TIMEOUT_CNT) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          rd_data_d   = '0;
          err_d       = 1'b1;
          reg_write_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding transaction
  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pc_src_q    <= 1'b0;
      br_addr_q   <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      alu_q       <= '0;
      wb_radr_q   <= '0;
      reg_write_q <= 1'b0;
      mem_2_reg_q <= 1'b0;
      err_q       <= 1'b0;
      pend_rw_q   <= 1'b0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_src_q    <= pc_src_d;
      br_addr_q   <= br_addr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      alu_q       <= alu_d;
      wb_radr_q   <= wb_radr_d;
      reg_write_q <= reg_write_d;
      mem_2_reg_q <= mem_2_reg_d;
      err_q       <= err_d;
      pend_rw_q   <= pend_rw_d;
      is_load_q   <= is_load_d;
    end
  end

  assign pc_src_87          = pc_src_q;
  assign br_addr_out_87     = br_addr_q;
  assign dmem.dmem_req_87   = req_q;
  assign dmem.dmem_we_87    = we_q;
  assign dmem.dmem_addr_87  = addr_q;
  assign dmem.dmem_wdata_87 = wdata_q;
  assign rd_data_out_87     = rd_data_q;
  assign alu_out_87         = alu_q;
  assign wb_radr_out_87     = wb_radr_q;
  assign reg_write_out_87   = reg_write_q;
  assign mem_2_reg_out_87   = mem_2_reg_q;
  assign err_87             = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;
  localparam int TIMEOUT = 15;

  logic        clk_87 = 1'b0;
  logic        rst_n_87;
  logic        zero_in_87, branch_in_87, mem_read_in_87, mem_write_in_87;
  logic        reg_write_in_87, mem_2_reg_in_87;
  logic [31:0] br_addr_in_87, alu_in_87, st_data_in_87;
  logic [4:0]  wb_radr_in_87;
  logic        stall_87, pc_src_87, reg_write_out_87, mem_2_reg_out_87, err_87;
  logic [31:0] br_addr_out_87, rd_data_out_87, alu_out_87;
  logic [4:0]  wb_radr_out_87;

  mem_access_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dmem_if ();

  mem_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT(TIMEOUT)) dut (
    .clk_87(clk_87), .rst_n_87(rst_n_87), .zero_in_87(zero_in_87),
    .br_addr_in_87(br_addr_in_87), .alu_in_87(alu_in_87), .st_data_in_87(st_data_in_87),
    .wb_radr_in_87(wb_radr_in_87), .branch_in_87(branch_in_87),
    .mem_read_in_87(mem_read_in_87), .mem_write_in_87(mem_write_in_87),
    .reg_write_in_87(reg_write_in_87), .mem_2_reg_in_87(mem_2_reg_in_87),
    .stall_87(stall_87), .pc_src_87(pc_src_87), .br_addr_out_87(br_addr_out_87),
    .dmem(dmem_if.master), .rd_data_out_87(rd_data_out_87), .alu_out_87(alu_out_87),
    .wb_radr_out_87(wb_radr_out_87), .reg_write_out_87(reg_write_out_87),
    .mem_2_reg_out_87(mem_2_reg_out_87), .err_87(err_87)
  );

  always #5 clk_87 = ~clk_87;

  int checks = 0;
  int failures = 0;

  // reference model: architectural state visible at the WB side plus a word memory
  logic [31:0] exp_rd;
  logic        exp_err;
  logic [31:0] mem_model [int];

  typedef struct {
    logic        br, zero, mr, mw, rw, m2r;
    logic [4:0]  radr;
    logic [31:0] alu, bra;
    logic        e_stall, e_pc_src, e_rw, e_err;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_87);
    #1;
  endtask

  task automatic drive(input logic mr, mw, br, zero, rw, m2r, input logic [4:0] radr,
                       input logic [31:0] alu, st, bra);
    mem_read_in_87 = mr; mem_write_in_87 = mw; branch_in_87 = br; zero_in_87 = zero;
    reg_write_in_87 = rw; mem_2_reg_in_87 = m2r; wb_radr_in_87 = radr;
    alu_in_87 = alu; st_data_in_87 = st; br_addr_in_87 = bra;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    dmem_if.dmem_ack_87 = 1'b0;
    rst_n_87 = 1'b0;
    repeat (2) @(posedge clk_87);
    @(negedge clk_87);
    rst_n_87 = 1'b1;
    exp_rd = '0;
    exp_err = 1'b0;
    tick();
  endtask

  // dly = cycle after issue in which ack arrives; dly > TIMEOUT means never
  task automatic run_instr(input string tag, input logic mr, mw, br, zero, rw, m2r,
                           input logic [4:0] radr, input logic [31:0] alu, st, bra,
                           input int dly);
    logic [31:0] rdata;
    bit acked;
    drive(mr, mw, br, zero, rw, m2r, radr, alu, st, bra);
    dmem_if.dmem_ack_87 = 1'b0;
    #1;
    if (!(mr | mw)) begin
      chk({tag, ".stall"}, stall_87, 0);
      tick();
      chk({tag, ".alu"}, alu_out_87, alu);
      chk({tag, ".radr"}, wb_radr_out_87, radr);
      chk({tag, ".rw"}, reg_write_out_87, rw);
      chk({tag, ".m2r"}, mem_2_reg_out_87, m2r);
      chk({tag, ".pc_src"}, pc_src_87, br & zero);
      chk({tag, ".br_addr"}, br_addr_out_87, bra);
      chk({tag, ".rd"}, rd_data_out_87, exp_rd);
      chk({tag, ".err"}, err_87, exp_err);
      chk({tag, ".req"}, dmem_if.dmem_req_87, 0);
    end else if (alu[1:0] != 2'b00) begin
      chk({tag, ".stall"}, stall_87, 0);
      tick();
      exp_err = 1'b1;
      chk({tag, ".req"}, dmem_if.dmem_req_87, 0);
      chk({tag, ".err"}, err_87, 1);
      chk({tag, ".rw"}, reg_write_out_87, 0);
      chk({tag, ".rd"}, rd_data_out_87, exp_rd);
    end else begin
      chk({tag, ".stall0"}, stall_87, 1);
      tick();
      chk({tag, ".req"}, dmem_if.dmem_req_87, 1);
      chk({tag, ".addr"}, dmem_if.dmem_addr_87, alu);
      chk({tag, ".we"}, dmem_if.dmem_we_87, mw & ~mr);
      chk({tag, ".wdata"}, dmem_if.dmem_wdata_87, st);
      chk({tag, ".bubble"}, reg_write_out_87, 0);
      acked = 0;
      rdata = '0;
      for (int c = 1; c <= TIMEOUT; c++) begin
        if (c == dly) begin
          rdata = (mr && mem_model.exists(int'(alu))) ? mem_model[int'(alu)] : $urandom;
          dmem_if.dmem_rdata_87 = rdata;
          dmem_if.dmem_ack_87 = 1'b1;
          #1;
          chk({tag, ".stall_ack"}, stall_87, 0);
          tick();
          dmem_if.dmem_ack_87 = 1'b0;
          acked = 1;
          break;
        end
        #1;
        chk({tag, ".stall_busy"}, stall_87, 1);
        tick();
      end
      if (acked) begin
        if (mr) exp_rd = rdata;
        else mem_model[int'(alu)] = st;
        chk({tag, ".rw_done"}, reg_write_out_87, rw);
      end else begin
        exp_rd = '0;
        exp_err = 1'b1;
        chk({tag, ".rw_to"}, reg_write_out_87, 0);
      end
      chk({tag, ".req_done"}, dmem_if.dmem_req_87, 0);
      chk({tag, ".rd_done"}, rd_data_out_87, exp_rd);
      chk({tag, ".err_done"}, err_87, exp_err);
      chk({tag, ".alu_done"}, alu_out_87, alu);
      chk({tag, ".m2r_done"}, mem_2_reg_out_87, m2r);
      chk({tag, ".radr_done"}, wb_radr_out_87, radr);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{br:0, zero:0, mr:0, mw:0, rw:1, m2r:0, radr:5'd3, alu:32'h10, bra:32'h0,
                e_stall:0, e_pc_src:0, e_rw:1, e_err:0};
    vecs[1] = '{br:1, zero:1, mr:0, mw:0, rw:0, m2r:0, radr:5'd0, alu:32'h0, bra:32'h100,
                e_stall:0, e_pc_src:1, e_rw:0, e_err:0};
    vecs[2] = '{br:1, zero:0, mr:0, mw:0, rw:0, m2r:0, radr:5'd1, alu:32'h5, bra:32'h200,
                e_stall:0, e_pc_src:0, e_rw:0, e_err:0};
    vecs[3] = '{br:0, zero:1, mr:0, mw:0, rw:0, m2r:1, radr:5'd31, alu:32'hDEADBEEF, bra:32'h44,
                e_stall:0, e_pc_src:0, e_rw:0, e_err:0};
    vecs[4] = '{br:0, zero:0, mr:1, mw:0, rw:1, m2r:1, radr:5'd7, alu:32'h42, bra:32'h0,
                e_stall:0, e_pc_src:0, e_rw:0, e_err:1};

    dmem_if.dmem_rdata_87 = '0;
    dmem_if.dmem_ack_87 = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    rst_n_87 = 1'b0;
    repeat (2) @(posedge clk_87);
    #1;
    chk("rst.req", dmem_if.dmem_req_87, 0);
    chk("rst.err", err_87, 0);
    chk("rst.pc_src", pc_src_87, 0);
    chk("rst.rw", reg_write_out_87, 0);
    chk("rst.rd", rd_data_out_87, 0);
    chk("rst.alu", alu_out_87, 0);
    @(negedge clk_87);
    rst_n_87 = 1'b1;
    exp_rd = '0;
    exp_err = 1'b0;
    tick();

    // single-cycle vectors
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].zero, vecs[i].rw, vecs[i].m2r,
            vecs[i].radr, vecs[i].alu, 32'd0, vecs[i].bra);
      #1;
      chk($sformatf("vec%0d.stall", i), stall_87, vecs[i].e_stall);
      tick();
      chk($sformatf("vec%0d.alu", i), alu_out_87, vecs[i].alu);
      chk($sformatf("vec%0d.radr", i), wb_radr_out_87, vecs[i].radr);
      chk($sformatf("vec%0d.rw", i), reg_write_out_87, vecs[i].e_rw);
      chk($sformatf("vec%0d.pc_src", i), pc_src_87, vecs[i].e_pc_src);
      chk($sformatf("vec%0d.err", i), err_87, vecs[i].e_err);
      chk($sformatf("vec%0d.req", i), dmem_if.dmem_req_87, 0);
      if (!(vecs[i].mr | vecs[i].mw))
        chk($sformatf("vec%0d.br_addr", i), br_addr_out_87, vecs[i].bra);
    end
    exp_err = 1'b1;

    // load with 3 stall cycles, then store with 1
    mem_model[32'h40] = 32'hCAFEF00D;
    run_instr("load40", 1, 0, 0, 0, 1, 1, 5'd9, 32'h40, 32'h0, 32'h0, 3);
    chk("load40.value", rd_data_out_87, 32'hCAFEF00D);
    run_instr("store80", 0, 1, 0, 0, 0, 0, 5'd0, 32'h80, 32'h12345678, 32'h0, 1);
    chk("store80.rd_kept", rd_data_out_87, 32'hCAFEF00D);
    run_instr("ldst_both", 1, 1, 0, 0, 1, 1, 5'd4, 32'h84, 32'h55, 32'h0, 2);

    // ack in the timeout cycle wins; then a real timeout
    do_reset();
    run_instr("ack_at_to", 1, 0, 0, 0, 1, 1, 5'd2, 32'h8, 32'h0, 32'h0, TIMEOUT);
    chk("ack_at_to.no_err", err_87, 0);
    run_instr("timeout", 1, 0, 0, 0, 1, 1, 5'd2, 32'hC, 32'h0, 32'h0, TIMEOUT + 1);
    chk("timeout.rd0", rd_data_out_87, 0);
    chk("timeout.err", err_87, 1);

    // reset pulsed while BUSY
    drive(1, 0, 0, 0, 1, 1, 5'd6, 32'h20, 32'h0, 32'h0);
    #1;
    chk("rstbusy.stall", stall_87, 1);
    tick();
    chk("rstbusy.req_before", dmem_if.dmem_req_87, 1);
    drive(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    #2;
    rst_n_87 = 1'b0;
    #1;
    chk("rstbusy.req", dmem_if.dmem_req_87, 0);
    chk("rstbusy.idle", stall_87, 0);
    chk("rstbusy.rw", reg_write_out_87, 0);
    chk("rstbusy.err", err_87, 0);
    @(negedge clk_87);
    rst_n_87 = 1'b1;
    exp_rd = '0;
    exp_err = 1'b0;
    tick();
    run_instr("post_rst", 0, 0, 0, 0, 1, 0, 5'd10, 32'h77, 32'h0, 32'h0, 0);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      int kind;
      int dly;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(1, 4);
      a = 32'($urandom_range(0, 15)) << 2;
      case (kind)
        0: run_instr($sformatf("rnd%0d", n), 0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 0);
        1: run_instr($sformatf("rnd%0d", n), 1, 1'($urandom), 0, 0, 1'($urandom), 1,
                     5'($urandom), a, $urandom, 32'h0, dly);
        2: run_instr($sformatf("rnd%0d", n), 0, 1, 0, 0, 0, 0, 5'($urandom), a, $urandom,
                     32'h0, dly);
        default: run_instr($sformatf("rnd%0d", n), 1'($urandom), 1, 0, 0, 1, 1, 5'($urandom),
                           a | 32'($urandom_range(1, 3)), $urandom, 32'h0, 0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
